// File: rtl/mic_control_if.sv
// ADC-side pins and the deserialized sample bus of mic_control.
// The master modport is the controller side; the slave modport is the ADC/consumer side.
interface mic_control_if;
   logic        audio_sdout;
   logic        audio_mclk;
   logic        audio_lrck;
   logic        audio_sck;
   logic [15:0] audio_out_left;
   logic [15:0] audio_out_right;
   logic        sample_valid;
   logic [14:0] level;

   modport master (
      input  audio_sdout,
      output audio_mclk, audio_lrck, audio_sck,
      output audio_out_left, audio_out_right, sample_valid, level
   );

   modport slave (
      output audio_sdout,
      input  audio_mclk, audio_lrck, audio_sck,
      input  audio_out_left, audio_out_right, sample_valid, level
   );
endinterface

// File: rtl/mic_control.sv
// I2S receive controller: derives ADC clocks from clk, deserializes 16-bit stereo
// samples with a one-cycle valid strobe, and tracks a windowed peak level.
module mic_control #(
   parameter int LEVEL_WINDOW_LOG2 = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          enable,
   mic_control_if.master bus
);
   localparam int LW = LEVEL_WINDOW_LOG2;

   logic [8:0]    cnt_reg;
   logic          sdin_q_reg;
   logic [15:0]   shift_reg;
   logic [15:0]   left_hold_reg;
   logic          left_ok_reg;
   logic          primed_reg;
   logic [15:0]   out_left_reg;
   logic [15:0]   out_right_reg;
   logic          valid_reg;
   logic [14:0]   level_reg;
   logic [14:0]   peak_acc_reg;
   logic [LW-1:0] frame_cnt_reg;

   logic          capture;
   logic [15:0]   word_next;
   logic [14:0]   mag_l;
   logic [14:0]   mag_r;
   logic [14:0]   peak_next;

   // -32768 has no positive counterpart, so it saturates to 32767.
   function automatic logic [14:0] mag(input logic [15:0] x);
      logic [15:0] neg;
      neg = -x;
      if (x == 16'h8000)
         return 15'h7fff;
      else if (x[15])
         return neg[14:0];
      else
         return x[14:0];
   endfunction

   assign capture   = (cnt_reg[3:0] == 4'd9);
   assign word_next = {shift_reg[14:0], sdin_q_reg};
   assign mag_l     = mag(out_left_reg);
   assign mag_r     = mag(out_right_reg);

   always_comb begin
      peak_next = peak_acc_reg;
      if (mag_l > peak_next)
         peak_next = mag_l;
      if (mag_r > peak_next)
         peak_next = mag_r;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_reg       <= '0;
         sdin_q_reg    <= 1'b0;
         shift_reg     <= '0;
         left_hold_reg <= '0;
         left_ok_reg   <= 1'b0;
         primed_reg    <= 1'b0;
         out_left_reg  <= '0;
         out_right_reg <= '0;
         valid_reg     <= 1'b0;
         level_reg     <= '0;
         peak_acc_reg  <= '0;
         frame_cnt_reg <= '0;
      end else begin
         cnt_reg    <= cnt_reg + 9'd1;
         sdin_q_reg <= bus.audio_sdout;
         valid_reg  <= 1'b0;

         if (capture)
            shift_reg <= word_next;
         if (cnt_reg == 9'd265)
            left_hold_reg <= word_next;

         // A pair is delivered only if enable stayed high from the first left
         // bit capture (cnt 25) through the right completion (cnt 9).
         if (!enable) begin
            left_ok_reg <= 1'b0;
            primed_reg  <= 1'b0;
         end else begin
            if (cnt_reg == 9'd25)
               left_ok_reg <= 1'b1;
            if (cnt_reg == 9'd265)
               primed_reg <= left_ok_reg;
            if (cnt_reg == 9'd9 && primed_reg) begin
               out_left_reg  <= left_hold_reg;
               out_right_reg <= word_next;
               valid_reg     <= 1'b1;
            end
         end

         // Level is folded from the registered pair, one cycle after the strobe.
         if (valid_reg) begin
            frame_cnt_reg <= frame_cnt_reg + LW'(1);
            if (&frame_cnt_reg) begin
               level_reg    <= peak_next;
               peak_acc_reg <= '0;
            end else begin
               peak_acc_reg <= peak_next;
            end
         end
      end
   end

   assign bus.audio_mclk      = cnt_reg[1] & ~rst;
   assign bus.audio_sck       = cnt_reg[3] & ~rst;
   assign bus.audio_lrck      = cnt_reg[8] & ~rst;
   assign bus.audio_out_left  = out_left_reg;
   assign bus.audio_out_right = out_right_reg;
   assign bus.sample_valid    = valid_reg;
   assign bus.level           = level_reg;
endmodule

// File: tb/tb_mic_control.sv
// Self-checking bench for mic_control: I2S source model, frame-level delivery
// and level reference model, directed tables and randomized enable/data.
module tb_mic_control;
   localparam int LW  = 2;
   localparam int WIN = 1 << LW;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic enable = 1'b1;

   mic_control_if bus();

   mic_control #(.LEVEL_WINDOW_LOG2(LW)) dut (
      .clk    (clk),
      .rst    (rst),
      .enable (enable),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] in_l;
      logic [15:0] in_r;
      logic [15:0] exp_l;
      logic [15:0] exp_r;
   } pair_vec_t;

   typedef struct {
      logic [15:0] in_l;
      logic [15:0] in_r;
      int          exp_level;
   } level_vec_t;

   int          n_checks = 0;
   int          n_fail   = 0;
   int          tc;
   logic [15:0] fl [64];
   logic [15:0] fr [64];
   bit          en_hist [32768];
   logic [15:0] exp_l, exp_r;
   int          exp_level, run_max, pend_level, pend_at, nvalid;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         if (n_fail <= 30)
            $display("FAIL %s t=%0d actual=%h expected=%h", name, tc, act, exp);
      end
   endtask

   function automatic int mag_of(input logic [15:0] x);
      int v;
      v = int'($signed(x));
      if (v < 0) v = -v;
      if (v > 32767) v = 32767;
      return v;
   endfunction

   // A pair appears at cnt 10 of frame f when enable was high over the whole
   // span from the first left bit capture of frame f-1 to the right completion.
   function automatic bit expect_valid(input int t);
      int f;
      if (t % 512 != 10 || t < 522) return 1'b0;
      f = t / 512;
      for (int i = 512 * f - 487; i <= 512 * f + 9; i++)
         if (!en_hist[i]) return 1'b0;
      return 1'b1;
   endfunction

   task automatic model_reset();
      tc = 0; exp_l = '0; exp_r = '0;
      exp_level = 0; run_max = 0; pend_level = 0; pend_at = -1; nvalid = 0;
   endtask

   task automatic check_cycle();
      bit ev;
      int f, m;
      chk("mclk", 32'(bus.audio_mclk), 32'((tc >> 1) & 1));
      chk("sck",  32'(bus.audio_sck),  32'((tc >> 3) & 1));
      chk("lrck", 32'(bus.audio_lrck), 32'((tc >> 8) & 1));
      if (pend_at == tc) exp_level = pend_level;
      ev = expect_valid(tc);
      if (ev) begin
         f = tc / 512;
         exp_l = fl[f - 1];
         exp_r = fr[f - 1];
         nvalid++;
         m = run_max;
         if (mag_of(exp_l) > m) m = mag_of(exp_l);
         if (mag_of(exp_r) > m) m = mag_of(exp_r);
         if (nvalid % WIN == 0) begin
            pend_level = m; pend_at = tc + 1; run_max = 0;
         end else begin
            run_max = m;
         end
         $display("t=%0d pair L=%h R=%h got L=%h R=%h", tc, exp_l, exp_r,
                  bus.audio_out_left, bus.audio_out_right);
      end
      chk("valid", 32'(bus.sample_valid), 32'(ev));
      chk("left",  32'(bus.audio_out_left), 32'(exp_l));
      chk("right", 32'(bus.audio_out_right), 32'(exp_r));
      chk("level", 32'(bus.level), 32'(exp_level));
   endtask

   // I2S source: slot 0 carries the previous frame's right LSB.
   task automatic drive();
      int c, s, f;
      logic [15:0] w;
      logic b;
      c = tc % 512; s = c >> 4; f = tc >> 9;
      if (s == 0) begin
         w = (f == 0) ? 16'h0000 : fr[f - 1];
         b = w[0];
      end else if (s <= 16) begin
         w = fl[f];
         b = w[16 - s];
      end else begin
         w = fr[f];
         b = w[32 - s];
      end
      bus.audio_sdout = b;
      en_hist[tc] = enable;
   endtask

   task automatic step();
      drive();
      @(posedge clk);
      #1;
      tc++;
      check_cycle();
   endtask

   task automatic run_to(input int t_end);
      while (tc < t_end) step();
   endtask

   task automatic do_reset(input int n);
      rst = 1'b1;
      for (int i = 0; i < n; i++) begin
         bus.audio_sdout = 1'($urandom);
         @(posedge clk);
         #1;
         chk("rst_valid", 32'(bus.sample_valid), 32'd0);
         chk("rst_left",  32'(bus.audio_out_left), 32'd0);
         chk("rst_right", 32'(bus.audio_out_right), 32'd0);
         chk("rst_level", 32'(bus.level), 32'd0);
         chk("rst_clks",  32'({bus.audio_mclk, bus.audio_sck, bus.audio_lrck}), 32'd0);
      end
      rst = 1'b0;
      model_reset();
      check_cycle();
   endtask

   pair_vec_t  pair_tbl [7];
   level_vec_t lvl_tbl  [10];

   initial begin
      pair_tbl[0] = '{16'hA5C3, 16'h1234, 16'hA5C3, 16'h1234};
      pair_tbl[1] = '{16'hA5C3, 16'h1234, 16'hA5C3, 16'h1234};
      pair_tbl[2] = '{16'hA5C3, 16'h1234, 16'hA5C3, 16'h1234};
      pair_tbl[3] = '{16'h8000, 16'h7FFF, 16'h8000, 16'h7FFF};
      pair_tbl[4] = '{16'h0001, 16'hFFFF, 16'h0001, 16'hFFFF};
      pair_tbl[5] = '{16'h8000, 16'h7FFF, 16'h8000, 16'h7FFF};
      pair_tbl[6] = '{16'h0001, 16'hFFFF, 16'h0001, 16'hFFFF};

      lvl_tbl[0] = '{16'd100,  16'hFF9C, 0};
      lvl_tbl[1] = '{16'd100,  16'h8000, 0};
      lvl_tbl[2] = '{16'hFF9C, 16'd100,  0};
      lvl_tbl[3] = '{16'd100,  16'hFF9C, 32767};
      lvl_tbl[4] = '{16'hFF9C, 16'd100,  32767};
      lvl_tbl[5] = '{16'd100,  16'hFF9C, 32767};
      lvl_tbl[6] = '{16'hFF9C, 16'd100,  32767};
      lvl_tbl[7] = '{16'd100,  16'hFF9C, 100};
      lvl_tbl[8] = '{16'hFF9C, 16'd100,  100};
      lvl_tbl[9] = '{16'd100,  16'hFF9C, 100};

      for (int i = 0; i < 64; i++) begin
         fl[i] = 16'($urandom);
         fr[i] = 16'($urandom);
      end
      model_reset();
      bus.audio_sdout = 1'b0;

      // Power-up reset, then the directed pair table.
      do_reset(5);
      for (int i = 0; i < 7; i++) begin
         fl[i] = pair_tbl[i].in_l;
         fr[i] = pair_tbl[i].in_r;
      end
      for (int i = 0; i < 7; i++) begin
         run_to(512 * (i + 1) + 9);
         chk("tbl_pre_valid", 32'(bus.sample_valid), 32'd0);
         step();
         chk("tbl_valid", 32'(bus.sample_valid), 32'd1);
         chk("tbl_left",  32'(bus.audio_out_left),  32'(pair_tbl[i].exp_l));
         chk("tbl_right", 32'(bus.audio_out_right), 32'(pair_tbl[i].exp_r));
      end

      // Enable dropped mid-left-word for three frames, restored mid-left-word.
      run_to(8 * 512 + 150);
      enable = 1'b0;
      run_to(11 * 512 + 150);
      enable = 1'b1;
      run_to(12 * 512 + 10);
      chk("drop_no_valid", 32'(bus.sample_valid), 32'd0);
      chk("drop_hold_l",   32'(bus.audio_out_left),  32'(fl[7]));
      chk("drop_hold_r",   32'(bus.audio_out_right), 32'(fr[7]));
      run_to(13 * 512 + 10);
      chk("drop_resume", 32'(bus.sample_valid), 32'd1);
      chk("drop_res_l",  32'(bus.audio_out_left),  32'(fl[12]));
      chk("drop_res_r",  32'(bus.audio_out_right), 32'(fr[12]));

      // Enable low only on the right-completion cycle blocks that one pair.
      run_to(14 * 512 + 9);
      enable = 1'b0;
      step();
      enable = 1'b1;
      chk("edge_no_valid", 32'(bus.sample_valid), 32'd0);
      run_to(15 * 512 + 10);
      chk("edge_resume", 32'(bus.sample_valid), 32'd1);

      // Reset at cnt 200, then the level window table.
      run_to(16 * 512 + 200);
      do_reset(2);
      for (int i = 0; i < 10; i++) begin
         fl[i] = lvl_tbl[i].in_l;
         fr[i] = lvl_tbl[i].in_r;
      end
      run_to(521);
      chk("rr_pre_valid", 32'(bus.sample_valid), 32'd0);
      step();
      chk("rr_valid", 32'(bus.sample_valid), 32'd1);
      chk("rr_left",  32'(bus.audio_out_left),  32'(lvl_tbl[0].in_l));
      chk("rr_right", 32'(bus.audio_out_right), 32'(lvl_tbl[0].in_r));
      for (int i = 0; i < 10; i++) begin
         run_to(512 * (i + 1) + 12);
         chk("tbl_level", 32'(bus.level), 32'(lvl_tbl[i].exp_level));
      end

      // Randomized data and enable drop-outs against the frame model.
      for (int i = 11; i < 64; i++) begin
         fl[i] = 16'($urandom);
         fr[i] = 16'($urandom);
      end
      begin
         int drop_left = 0;
         while (tc < 30 * 512) begin
            if (drop_left == 0 && $urandom_range(0, 1499) == 0)
               drop_left = $urandom_range(1, 700);
            if (drop_left > 0) begin
               enable = 1'b0;
               drop_left--;
            end else begin
               enable = 1'b1;
            end
            step();
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/mic_control.md
# mic_control

Receive-side companion to the on-board speaker path. Generates the ADC master, word and serial clocks from the crystal clock, deserializes the ADC's I2S data line into 16-bit left/right samples, and presents each stereo pair with a one-cycle valid strobe. It also tracks a windowed peak magnitude for level metering. It sits between the microphone/line-in ADC pins and the audio processing logic.

## Interface
- LEVEL_WINDOW_LOG2, default 8: peak-level window length is 2^LEVEL_WINDOW_LOG2 valid frames.
- clk  input  1  crystal clock; all logic is on its rising edge.
- rst  input  1  synchronous, active-high reset.
- enable  input  1  high: deliver samples; low: suppress delivery and hold outputs.
- audio_sdout  input  1  serial data from the ADC, I2S format.
- audio_mclk  output  1  master clock, equal to cnt[1] (clk/4).
- audio_lrck  output  1  word select, equal to cnt[8] (clk/512); 0 = left, 1 = right.
- audio_sck  output  1  serial bit clock, equal to cnt[3] (clk/16).
- audio_out_left  output  16  last complete left sample, two's complement.
- audio_out_right  output  16  last complete right sample, two's complement.
- sample_valid  output  1  one-clk pulse when a new left/right pair is on the outputs.
- level  output  15  peak |sample| over the previous window.

## Operation
- cnt is a 9-bit free-running counter; rst clears it to 0, and it wraps 511→0. All clock outputs are decoded combinationally from cnt and are 0 during reset.
- sdin_q is audio_sdout registered once every clk.
- Bit slot = cnt[8:4], giving 32 slots per frame. Capture sdin_q into the shift register in the cycle where cnt[3:0]==9, i.e. mid-bit after the sck rising edge.
- I2S one-bit delay:
  - slot 0 = right[0] of the previous frame;
  - slots 1..16 = left[15:0], MSB first;
  - slots 17..31 = right[15:1].
- Left complete at the slot 16 capture (cnt==265). Copy to left_hold and set primed.
- Right complete at the slot 0 capture (cnt==9). If primed and enable are both high, load audio_out_left←left_hold and audio_out_right←the assembled right word together. Then pulse sample_valid.
- Delivery is suppressed for the first right completion after reset, because primed=0.
- enable low:
  - primed clears, sample_valid stays 0, and the out registers hold their value;
  - clocks keep running and capture continues.
- After enable rises, the first pair is delivered at the first right completion that follows a full left word captured with enable high.
- Level:
  - On each valid frame, compute mag = |x| for both channels. -32768 saturates to 32767.
  - peak_acc ← max(peak_acc, magL, magR).
  - The frame counter increments per valid frame. When it wraps, level ← the max including the current frame, and peak_acc clears to 0.
  - The frame counter and peak_acc are not cleared by enable.
- Reset values: cnt, shift register, left_hold, primed, audio_out_*, sample_valid, level, peak_acc and the frame counter are all 0.

## Timing
- Cycle index is t; t=0 is the first cycle with rst low, and cnt=t mod 512.
- First possible sample_valid is the cycle with cnt==10 of the second frame (t=522). After that it repeats every 512 clk while enable stays high.
- audio_out_* change on the same edge that raises sample_valid and stay stable for 512 clk.
- Latency from the right[0] bit centre at the pin to sample_valid is 2 clk: pin register, then capture/load.
- level updates in the cycle after the valid that completes a window. First update at t=522+512·(2^LEVEL_WINDOW_LOG2−1)+1.
- rst mid-frame discards partial words and all state. It restarts exactly as from power-up on the next cycle.
- enable sampled at the right-completion cycle (cnt==9) decides delivery. enable falling on that exact cycle means no delivery.

## Test plan
- Reset check: hold rst 5 clk -> every output is 0, and cnt and the clocks restart at 0 after release.
- I2S model drives left=0xA5C3, right=0x1234 every frame -> the first sample_valid is at t=522 with outputs 0xA5C3/0x1234, then a pulse every 512 clk with the same values.
- Alternate per-frame pairs (0x8000/0x7FFF, then 0x0001/0xFFFF) -> each valid shows the matching pair, with no left/right swap or bit shift.
- Drop enable for 3 frames starting mid-left-word -> no valid pulses and the outputs hold. After enable returns, the first valid comes at the first right completion following a full left word.
- LEVEL_WINDOW_LOG2=2 with right=0x8000 in one frame and otherwise ±100 -> level=32767 after the window, then 100 after the next window.
- Assert rst at cnt==200 mid-left-word -> outputs clear, and the next valid is 522 clk after release with correct data.
